// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and defaults for the data-memory arbiter
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, CPU, LDR, LDR_LOCK} owner_e;
  typedef enum logic {P_CPU, P_LDR} port_e;
  localparam logic [31:0] IO_ADDR_DEF = 32'hFFFF_FFFC;
endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] q
);
  always_ff @(posedge clk)
    q <= clr ? '0 : (en && !(&q)) ? q + 1'b1 : q;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin share of the data-memory port between CPU and loader
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int          MAX_BURST = 4,
  parameter logic [31:0] IO_ADDR   = IO_ADDR_DEF,
  parameter int          CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             cpu_req,
  input  logic [31:0]      cpu_A,
  input  logic [31:0]      cpu_WD,
  input  logic             cpu_WE,
  output logic             cpu_gnt,
  output logic [31:0]      cpu_RD,
  output logic             cpu_stall,
  input  logic             ldr_req,
  input  logic             ldr_lock,
  input  logic [31:0]      ldr_A,
  input  logic [31:0]      ldr_WD,
  input  logic             ldr_WE,
  output logic             ldr_gnt,
  output logic [31:0]      ldr_RD,
  output logic             ldr_err,
  output logic [31:0]      mem_A,
  output logic [31:0]      mem_WD,
  output logic             mem_WE,
  input  logic [31:0]      mem_RD,
  output logic [CNT_W-1:0] stall_count
);
  localparam int BW = $clog2(MAX_BURST + 1);
  owner_e        owner_q, owner_d;
  port_e         last_q, last_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          err_q, err_d;
  logic          ldr_pick, io_hit;
  always_comb begin
    ldr_pick  = ldr_req & (~cpu_req | last_q == P_CPU
                | (owner_q == LDR_LOCK && burst_q < BW'(MAX_BURST)));
    ldr_gnt   = ~RESET & ldr_pick;
    cpu_gnt   = ~RESET & cpu_req & ~ldr_pick;
    cpu_stall = ~RESET & cpu_req & ~cpu_gnt;
    io_hit    = ldr_A == IO_ADDR;
    mem_A     = cpu_gnt ? cpu_A : ldr_gnt ? ldr_A : '0;
    mem_WD    = cpu_gnt ? cpu_WD : ldr_gnt ? ldr_WD : '0;
    mem_WE    = cpu_gnt ? cpu_WE : ldr_gnt & ldr_WE & ~io_hit;
    cpu_RD    = cpu_gnt ? mem_RD : '0;
    ldr_RD    = (ldr_gnt && !io_hit) ? mem_RD : '0;
    owner_d   = cpu_gnt ? CPU : ldr_gnt ? (ldr_lock ? LDR_LOCK : LDR) : IDLE;
    last_d    = cpu_gnt ? P_CPU : ldr_gnt ? P_LDR : last_q;
    burst_d   = (ldr_gnt && ldr_lock) ? burst_q + BW'(cpu_req) : '0;
    err_d     = ldr_gnt & io_hit;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      owner_q <= IDLE;
      last_q  <= P_LDR;
      burst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      err_q   <= err_d;
    end
  end
  assign ldr_err = err_q;
  sat_counter #(.CNT_W(CNT_W)) u_stall (
    .clk(CLK),
    .clr(RESET),
    .en (cpu_stall),
    .q  (stall_count)
  );
endmodule
